simon_decrypt_top: RTL and testbench

//  SIMON32/64 decryption engine; inverse of the SIMON encryption path fed by the TRNG key RAM.

---
 rtl/simon_decrypt_if.sv | 19 +
 rtl/simon_decrypt_top.sv | 143 ++++++++++++++
 tb/tb_simon_decrypt_top.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_decrypt_if.sv
// rtl/simon_decrypt_if.sv - start/done handshake bundle for the SIMON32/64 decrypt engine
interface simon_decrypt_if;
    logic        start;
    logic [63:0] key;
    logic [31:0] ciphertext;
    logic [31:0] plaintext;
    logic        busy;
    logic        done;

    modport master (
        output start, key, ciphertext,
        input  plaintext, busy, done
    );

    modport slave (
        input  start, key, ciphertext,
        output plaintext, busy, done
    );
endinterface

// File: rtl/simon_decrypt_top.sv
// rtl/simon_decrypt_top.sv - SIMON32/64 decryption engine: key expansion then 32 inverse rounds
module simon_decrypt_top #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    simon_decrypt_if.slave bus
);
    // z0 sequence, index 0 is the leftmost bit
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEYGEN,
        ST_DECRYPT,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N-1:0] rk [T];
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [4:0]   i;
    logic [5:0]   j;
    logic [31:0]  pt_q;
    logic         busy_q;
    logic         done_q;

    logic         load;
    logic         kg_en;
    logic         dec_en;
    logic         fin;

    logic [N-1:0] kg_a;
    logic [N-1:0] kg_b;
    logic [N-1:0] rk_new;
    logic [5:0]   z_idx;
    logic         z_bit;
    logic [N-1:0] f_y;
    logic [N-1:0] y_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (bus.start) state_nxt = ST_KEYGEN;
            ST_KEYGEN:  if (i == 5'd31) state_nxt = ST_DECRYPT;
            ST_DECRYPT: if (j == 6'd0) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        kg_en  = 1'b0;
        dec_en = 1'b0;
        fin    = 1'b0;
        unique case (state)
            ST_IDLE:    load   = bus.start;
            ST_KEYGEN:  kg_en  = 1'b1;
            ST_DECRYPT: dec_en = 1'b1;
            ST_DONE:    fin    = 1'b1;
            default:    load   = 1'b0;
        endcase
    end

    // Key expansion step for round key i, built from the three previously expanded words
    always_comb begin
        kg_a   = {rk[i - 5'd1][2:0], rk[i - 5'd1][15:3]} ^ rk[i - 5'd3];
        kg_b   = kg_a ^ {kg_a[0], kg_a[15:1]};
        z_idx  = 6'd61 - {1'b0, i - 5'd4};
        z_bit  = Z0[z_idx];
        rk_new = ~rk[i - 5'd4] ^ kg_b ^ {15'd0, z_bit} ^ 16'h0003;
    end

    always_comb begin
        f_y   = ({y[14:0], y[15]} & {y[7:0], y[15:8]}) ^ {y[13:0], y[15:14]};
        y_new = x ^ f_y ^ rk[j[4:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < T; k++) begin
                rk[k] <= '0;
            end
            x      <= '0;
            y      <= '0;
            i      <= '0;
            j      <= '0;
            pt_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                for (int k = 0; k < M; k++) begin
                    rk[k] <= bus.key[k*N +: N];
                end
                x      <= bus.ciphertext[31:16];
                y      <= bus.ciphertext[15:0];
                i      <= 5'd4;
                busy_q <= 1'b1;
            end
            if (kg_en) begin
                rk[i] <= rk_new;
                if (i == 5'd31) begin
                    j <= 6'd31;
                end else begin
                    i <= i + 5'd1;
                end
            end
            if (dec_en) begin
                x <= y;
                y <= y_new;
                if (j == 6'd0) begin
                    pt_q <= {y, y_new};
                end else begin
                    j <= j - 6'd1;
                end
            end
            if (fin) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.plaintext = pt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_simon_decrypt_top.sv
// tb/tb_simon_decrypt_top.sv - directed and round-trip checks for the SIMON32/64 decrypt engine
module tb_simon_decrypt_top;
    localparam logic [63:0] K1 = 64'h1918111009080100;
    localparam logic [31:0] C1 = 32'hC69BE9BB;
    localparam logic [31:0] P1 = 32'h65656877;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    simon_decrypt_if bus();

    simon_decrypt_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Forward SIMON32/64 encryption reference
    function automatic logic [31:0] simon_enc(input logic [63:0] k, input logic [31:0] pt);
        logic [15:0] ks [32];
        logic [15:0] xa, ya, t;
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int r = 0; r < 4; r++) ks[r] = k[16*r +: 16];
        for (int r = 4; r < 32; r++) begin
            t = {ks[r-1][2:0], ks[r-1][15:3]} ^ ks[r-3];
            t = t ^ {t[0], t[15:1]};
            ks[r] = ~ks[r-4] ^ t ^ {15'd0, z[61-(r-4)]} ^ 16'h0003;
        end
        xa = pt[31:16];
        ya = pt[15:0];
        for (int r = 0; r < 32; r++) begin
            t  = xa;
            xa = ya ^ ({xa[14:0], xa[15]} & {xa[7:0], xa[15:8]}) ^ {xa[13:0], xa[15:14]} ^ ks[r];
            ya = t;
        end
        return {xa, ya};
    endfunction

    task automatic run_op(input logic [63:0] k, input logic [31:0] c, output int lat);
        @(negedge clk);
        bus.key = k;
        bus.ciphertext = c;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (lat < 200 && !bus.done) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.key = '0;
        bus.ciphertext = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.plaintext !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got pt=%h busy=%b done=%b exp pt=0 busy=0 done=0",
                     bus.plaintext, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b done=%b exp 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_model();
        checks++;
        if (simon_enc(K1, P1) !== C1) begin
            failures++;
            $display("FAIL model_vector got=%h exp=%h", simon_enc(K1, P1), C1);
        end
    endtask

    task automatic test_known_vector();
        int n;
        @(negedge clk);
        bus.key = K1;
        bus.ciphertext = C1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL kv_busy_after_accept got=%b exp=1", bus.busy);
        end
        n = 0;
        while (n < 200 && !bus.done) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || n != 61) begin
            failures++;
            $display("FAIL kv_latency got=%0d done=%b exp=61", n, bus.done);
        end
        checks++;
        if (bus.plaintext !== P1) begin
            failures++;
            $display("FAIL kv_plaintext got=%h exp=%h", bus.plaintext, P1);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL kv_busy_at_done got=%b exp=0", bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.plaintext !== P1) begin
            failures++;
            $display("FAIL kv_done_single got done=%b pt=%h exp done=0 pt=%h", bus.done, bus.plaintext, P1);
        end
    endtask

    task automatic test_round_trip();
        logic [63:0] k;
        logic [31:0] p, c;
        int lat;
        for (int t = 0; t < 200; t++) begin
            k = {$urandom, $urandom};
            p = $urandom;
            c = simon_enc(k, p);
            run_op(k, c, lat);
            checks++;
            if (lat != 61 || bus.plaintext !== p) begin
                failures++;
                $display("FAIL round_trip_%0d got pt=%h lat=%0d exp pt=%h lat=61", t, bus.plaintext, lat, p);
            end
        end
    endtask

    task automatic test_ignored_start();
        int n_done, t_done;
        logic [31:0] pt_done;
        @(negedge clk);
        bus.key = K1;
        bus.ciphertext = C1;
        bus.start = 1'b1;
        @(posedge clk);
        n_done = 0;
        t_done = -1;
        pt_done = '0;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            if (c > 1 && bus.done) begin
                n_done++;
                if (t_done < 0) t_done = c - 1;
                pt_done = bus.plaintext;
            end
            bus.start = (c == 5 || c == 30 || c == 61);
            if (c == 10) bus.key = 64'hFFFF_FFFF_FFFF_FFFF;
            @(posedge clk);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (n_done != 1 || t_done != 61) begin
            failures++;
            $display("FAIL ignored_start_dones got=%0d first=%0d exp=1 first=61", n_done, t_done);
        end
        checks++;
        if (pt_done !== P1) begin
            failures++;
            $display("FAIL ignored_start_pt got=%h exp=%h", pt_done, P1);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start_idle got busy=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int n_done, lat;
        @(negedge clk);
        bus.key = K1;
        bus.ciphertext = C1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (39) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.plaintext !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset got pt=%h busy=%b done=%b exp 0 0 0", bus.plaintext, bus.busy, bus.done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            failures++;
            $display("FAIL midop_no_done got=%0d exp=0", n_done);
        end
        run_op(K1, C1, lat);
        checks++;
        if (lat != 61 || bus.plaintext !== P1) begin
            failures++;
            $display("FAIL midop_recover got pt=%h lat=%0d exp pt=%h lat=61", bus.plaintext, lat, P1);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] kk [3];
        logic [31:0] pp [3];
        logic [31:0] cc [3];
        int prev, w;
        kk[0] = K1;                    pp[0] = P1;
        kk[1] = 64'h0123456789ABCDEF;  pp[1] = 32'hDEADBEEF;
        kk[2] = 64'hFEDCBA9876543210;  pp[2] = 32'h00000001;
        for (int k = 0; k < 3; k++) cc[k] = simon_enc(kk[k], pp[k]);
        @(negedge clk);
        bus.key = kk[0];
        bus.ciphertext = cc[0];
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.key = kk[1];
        bus.ciphertext = cc[1];
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            do begin
                @(posedge clk);
                w++;
                @(negedge clk);
            end while (w < 100 && !bus.done);
            checks++;
            if (bus.done !== 1'b1 || bus.plaintext !== pp[k]) begin
                failures++;
                $display("FAIL b2b_op%0d got pt=%h done=%b exp pt=%h", k, bus.plaintext, bus.done, pp[k]);
            end
            if (k > 0) begin
                checks++;
                if (cyc - prev != 62) begin
                    failures++;
                    $display("FAIL b2b_gap%0d got=%0d exp=62", k, cyc - prev);
                end
            end
            prev = cyc;
            if (k == 2) bus.start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            bus.key = (k == 0) ? kk[2] : 64'h5555_AAAA_5555_AAAA;
            bus.ciphertext = (k == 0) ? cc[2] : 32'h1234_5678;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop got busy=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_zero_and_key_change();
        logic [63:0] k;
        logic [31:0] p, c;
        int lat, n;
        run_op(64'h0, 32'h0, lat);
        checks++;
        if (lat != 61 || simon_enc(64'h0, bus.plaintext) !== 32'h0) begin
            failures++;
            $display("FAIL zero_vector got pt=%h reenc=%h lat=%0d exp reenc=0 lat=61",
                     bus.plaintext, simon_enc(64'h0, bus.plaintext), lat);
        end
        k = 64'h0F1E2D3C4B5A6978;
        p = 32'h13579BDF;
        c = simon_enc(k, p);
        @(negedge clk);
        bus.key = k;
        bus.ciphertext = c;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (n < 200 && !bus.done) begin
            if (n == 3) begin bus.key = ~k; bus.ciphertext = ~c; end
            if (n == 40) begin bus.key = 64'h0; bus.ciphertext = 32'h1; end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 61 || bus.plaintext !== p) begin
            failures++;
            $display("FAIL key_change_midop got pt=%h lat=%0d exp pt=%h lat=61", bus.plaintext, n, p);
        end
    endtask

    initial begin
        test_reset();
        test_model();
        test_known_vector();
        test_round_trip();
        test_ignored_start();
        test_reset_mid_op();
        test_back_to_back();
        test_zero_and_key_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
